ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, lowest byte address mapped to RAM word 0.
REQ-002 SHALL have parameter IDX_W, default 24, number of valid RAM word-index bits; RAM holds 2^IDX_W 64-bit words.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req_valid in 1, i_req_ready out 1, i_req_addr in 64: instruction fetch request, byte address.
REQ-006 SHALL have ports i_resp_valid out 1, i_resp_data out 32, i_resp_err out 1: instruction response.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_req_addr in 64, d_req_wen in 1, d_req_wdata in 64, d_req_wmask in 64: data request.
REQ-008 SHALL have ports d_resp_valid out 1, d_resp_rdata out 64, d_resp_err out 1: data response.
REQ-009 SHALL have ports ram_en out 1, ram_idx out 64, ram_wen out 1, ram_wdata out 64, ram_wmask out 64: single-port RAM command.
REQ-010 SHALL have port ram_rdata in 64: RAM read data, valid the cycle after ram_en=1.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-012 In IDLE with at least one req_valid, SHALL assert ready only to the granted requester, same cycle (ready may depend combinationally on valid); a handshake (valid&ready) SHALL occur only in IDLE.
REQ-013 Tie (both valid) SHALL grant the requester not granted last; last_grant register resets to I, so first tie grants D; last_grant updates on every handshake.
REQ-014 On handshake SHALL register requester id, address, wen (0 for I), wdata, wmask.
REQ-015 Index = (addr - BASE_ADDR) >> 3, 64-bit arithmetic; request is out-of-range if addr < BASE_ADDR or index >= 2^IDX_W.
REQ-016 In-range handshake: IDLE -> ACCESS; out-of-range handshake: IDLE -> RESP with error, no RAM access.
REQ-017 ACCESS (exactly one cycle) SHALL drive ram_en=1, ram_idx=index, ram_wen=wen, ram_wdata/ram_wmask from registers; then -> RESP.
REQ-018 Outside ACCESS SHALL drive ram_en=0, ram_wen=0, ram_idx/ram_wdata/ram_wmask=0.
REQ-019 RESP (exactly one cycle) SHALL pulse resp_valid=1 to the owning requester only, then -> IDLE; no new handshake in RESP.
REQ-020 In-range read latency: handshake cycle T, ram_en at T+1, resp_valid at T+2; error latency: resp_valid at T+1.
REQ-021 D read response: d_resp_rdata = ram_rdata (combinational pass-through in RESP); D write response: d_resp_rdata = 0.
REQ-022 I response: i_resp_data = stored addr[2] ? ram_rdata[63:32] : ram_rdata[31:0].
REQ-023 Error response: resp_err=1, data=0; otherwise resp_err=0.
REQ-024 When resp_valid=0, resp data and err outputs SHALL be 0.
REQ-025 No response backpressure; requester SHALL accept the resp pulse.
REQ-026 Request inputs changing after handshake SHALL not affect the in-flight transaction.
REQ-027 Peak throughput one in-range transaction per 3 cycles; no starvation: with both continuously valid, grants strictly alternate.

Reset
REQ-028 Reset cycle SHALL force state IDLE, last_grant=I, all ready/resp_valid/ram_en/ram_wen outputs 0, captured registers 0.
REQ-029 Reset in ACCESS or RESP SHALL abort the transaction: no resp_valid pulse afterward; a write whose ACCESS cycle coincides with reset SHALL not reach the RAM (ram_wen=0).

Verification
REQ-030 I read addr 0x8000_0004, RAM word 0 = 0x1111_2222_3333_4444 -> ram_idx=0 at T+1, i_resp_data=0x1111_2222 at T+2.
REQ-031 D write addr 0x8000_0010, wdata 0xAB, wmask 0xFF, then D read same addr -> ram_wen=1 idx=2; read returns 0xAB; write resp rdata=0.
REQ-032 Both valid continuously from reset -> grant order D, I, D, I; each ready pulse 3 cycles apart.
REQ-033 D read addr 0x7FFF_FFF8 and addr BASE_ADDR + 2^IDX_W*8 -> ram_en never 1, d_resp_valid with d_resp_err=1, rdata=0 at T+1.
REQ-034 Reset asserted during ACCESS of a D write -> ram_wen=0 that cycle, no d_resp_valid, FSM in IDLE next cycle, next tie grants D.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single-port 64-bit RAM.
// Fair round-robin on ties, range check against BASE_ADDR, one transaction in flight.
module ram_arbiter #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          IDX_W     = 24
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_wen,
  input  logic [63:0] d_req_wdata,
  input  logic [63:0] d_req_wmask,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_rdata,
  output logic        d_resp_err,

  output logic        ram_en,
  output logic [63:0] ram_idx,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  // state  | meaning
  // IDLE   | waiting for a request; only state in which a handshake happens
  // ACCESS | one-cycle RAM command from the captured request
  // RESP   | one-cycle response pulse to the owning requester
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]  state;
  logic        last_grant;
  logic        owner_q;
  logic        wen_q;
  logic        err_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] wmask_q;

  logic        in_idle;
  logic        grant_d;
  logic        hs;
  logic [63:0] sel_addr;
  logic [63:0] sel_idx;
  logic        sel_oor;
  logic [63:0] idx_q;
  logic        resp_act;
  logic        resp_ok;

  // Ready is gated by reset so nothing can be accepted in the reset cycle.
  assign in_idle     = (state == IDLE) && !reset;
  assign grant_d     = d_req_valid && (!i_req_valid || (last_grant == GRANT_I));
  assign d_req_ready = in_idle && grant_d;
  assign i_req_ready = in_idle && i_req_valid && !grant_d;
  assign hs          = d_req_ready || i_req_ready;

  assign sel_addr = grant_d ? d_req_addr : i_req_addr;
  assign sel_idx  = (sel_addr - BASE_ADDR) >> 3;
  assign sel_oor  = (sel_addr < BASE_ADDR) || ((sel_idx >> IDX_W) != 64'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      owner_q    <= GRANT_I;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state      <= sel_oor ? RESP : ACCESS;
            last_grant <= grant_d;
            owner_q    <= grant_d;
            addr_q     <= sel_addr;
            wen_q      <= grant_d && d_req_wen;
            wdata_q    <= grant_d ? d_req_wdata : 64'd0;
            wmask_q    <= grant_d ? d_req_wmask : 64'd0;
            err_q      <= sel_oor;
          end
        end
        ACCESS:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign idx_q = (addr_q - BASE_ADDR) >> 3;

  // A reset landing on the ACCESS cycle must keep a write off the RAM.
  assign ram_en    = (state == ACCESS) && !reset;
  assign ram_wen   = ram_en && wen_q;
  assign ram_idx   = ram_en ? idx_q   : 64'd0;
  assign ram_wdata = ram_en ? wdata_q : 64'd0;
  assign ram_wmask = ram_en ? wmask_q : 64'd0;

  assign resp_act = (state == RESP) && !reset;
  assign resp_ok  = resp_act && !err_q;

  assign i_resp_valid = resp_act && (owner_q == GRANT_I);
  assign i_resp_err   = i_resp_valid && err_q;
  assign i_resp_data  = (resp_ok && (owner_q == GRANT_I))
                        ? (addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : 32'd0;

  assign d_resp_valid = resp_act && (owner_q == GRANT_D);
  assign d_resp_err   = d_resp_valid && err_q;
  assign d_resp_rdata = (resp_ok && (owner_q == GRANT_D) && !wen_q) ? ram_rdata : 64'd0;

endmodule
